// File: rtl/seq_divider.sv
// Sequential 32-bit restoring divider: one quotient bit per cycle, fixed 34-cycle latency.
// Operands arrive on two AXI-Stream-style channels; result is a one-cycle strobe.
module seq_divider #(
  parameter int SIGNED = 0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_divisor_tvalid,
  input  logic [31:0] s_axis_divisor_tdata,
  output logic        s_axis_divisor_tready,
  input  logic        s_axis_dividend_tvalid,
  input  logic [31:0] s_axis_dividend_tdata,
  output logic        s_axis_dividend_tready,
  output logic        m_axis_dout_tvalid,
  output logic [63:0] m_axis_dout_tdata
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic        ready_q;
  logic [4:0]  count;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs_mag;
  logic        neg_dvd;
  logic        neg_dvs;

  logic        accept;
  logic [31:0] dvd_in_mag;
  logic [31:0] dvs_in_mag;
  logic [32:0] partial;
  logic [32:0] trial;
  logic        borrow;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // ready_q is only ever set in IDLE, so it doubles as the state qualifier.
  assign accept                 = ready_q && s_axis_divisor_tvalid && s_axis_dividend_tvalid;
  assign s_axis_divisor_tready  = ready_q && aresetn;
  assign s_axis_dividend_tready = ready_q && aresetn;

  always_comb begin
    dvd_in_mag = s_axis_dividend_tdata;
    dvs_in_mag = s_axis_divisor_tdata;
    if ((SIGNED != 0) && s_axis_dividend_tdata[31]) dvd_in_mag = -s_axis_dividend_tdata;
    if ((SIGNED != 0) && s_axis_divisor_tdata[31])  dvs_in_mag = -s_axis_divisor_tdata;
  end

  // The partial remainder is always below the divisor, so its 33-bit shifted form
  // minus the divisor fits in 33 bits and bit 32 is exactly the borrow.
  always_comb begin
    partial = {rem, quo[31]};
    trial   = partial - {1'b0, dvs_mag};
    borrow  = trial[32];
  end

  // A zero divisor keeps the all-ones quotient regardless of operand signs.
  always_comb begin
    q_fix = quo;
    r_fix = rem;
    if ((neg_dvd != neg_dvs) && (dvs_mag != 32'd0)) q_fix = -quo;
    if (neg_dvd) r_fix = -rem;
  end

  always_ff @(posedge aclk) begin
    // NOTE: every register here uses <= so all updates see pre-edge values.
    if (!aresetn) begin
      state              <= IDLE;
      ready_q            <= 1'b0;
      count              <= 5'd0;
      rem                <= 32'd0;
      quo                <= 32'd0;
      dvs_mag            <= 32'd0;
      neg_dvd            <= 1'b0;
      neg_dvs            <= 1'b0;
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata  <= 64'd0;
    end else begin
      m_axis_dout_tvalid <= 1'b0;
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            rem     <= 32'd0;
            quo     <= dvd_in_mag;
            dvs_mag <= dvs_in_mag;
            neg_dvd <= (SIGNED != 0) && s_axis_dividend_tdata[31];
            neg_dvs <= (SIGNED != 0) && s_axis_divisor_tdata[31];
            count   <= 5'd0;
            ready_q <= 1'b0;
            state   <= CALC;
          end
        end
        CALC: begin
          rem   <= borrow ? partial[31:0] : trial[31:0];
          quo   <= {quo[30:0], ~borrow};
          count <= count + 5'd1;
          if (count == 5'd31) state <= FIX;
        end
        FIX: begin
          m_axis_dout_tdata  <= {q_fix, r_fix};
          m_axis_dout_tvalid <= 1'b1;
          ready_q            <= 1'b1;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
